// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_pkg
// Description : Shared widths, frame-FSM encodings and frame-length helper
//               for the ws2812 frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

  localparam int c_RGB_W = 24;
  localparam int c_CH_W  = 8;

  localparam int                c_ST_W     = 1;
  localparam logic [c_ST_W-1:0] c_ST_LATCH = 1'b0;
  localparam logic [c_ST_W-1:0] c_ST_RUN   = 1'b1;

  function automatic int frame_cycles(input int sys_clk_hz, input int frame_hz);
    return sys_clk_hz / frame_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter; a requester whose ack is
//               currently high is masked so a held request cannot win twice.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic [1:0] o_ack
);

  logic [1:0] r_ack;
  logic       r_favor_1;
  logic [1:0] w_elig;

  assign w_elig = i_req & ~r_ack;

  always_comb begin
    o_gnt = w_elig;
    if (w_elig == 2'b11) begin
      o_gnt = r_favor_1 ? 2'b10 : 2'b01;
    end
  end

  // The pointer only moves on a contested grant, and then points at the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack     <= 2'b00;
      r_favor_1 <= 1'b0;
    end else begin
      r_ack <= o_gnt;
      if (w_elig == 2'b11) begin
        r_favor_1 <= o_gnt[0];
      end
    end
  end

  assign o_ack = r_ack;

endmodule
`default_nettype wire

// File: rtl/ws2812_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_frame_sched
// Description : Double-buffered pixel store with two arbitrated writers, a
//               per-frame back-to-front copy and the driver latch/reset timing.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int SYSTEM_CLOCK = 48000000,
  parameter int FRAME_HZ     = 60,
  parameter int RESET_CYCLES = 4800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [23:0]       a_rgb,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [23:0]       b_rgb,
  output logic              b_ack,
  input  logic [2:0]        bright_shift,
  input  logic [ADDR_W-1:0] drv_address,
  input  logic              drv_new_address,
  output logic [7:0]        drv_red,
  output logic [7:0]        drv_green,
  output logic [7:0]        drv_blue,
  output logic              drv_reset,
  output logic              frame_sync
);

  localparam int                c_FRAME_CYCLES = frame_cycles(SYSTEM_CLOCK, FRAME_HZ);
  localparam int                c_FC_W         = (c_FRAME_CYCLES > 1) ? $clog2(c_FRAME_CYCLES) : 1;
  localparam logic [c_FC_W-1:0] c_FC_LAST      = c_FC_W'(c_FRAME_CYCLES - 1);
  localparam logic [c_FC_W-1:0] c_FC_LATCH_END = c_FC_W'(RESET_CYCLES - 1);

  logic [c_FC_W-1:0]  r_fc;
  logic               r_armed;
  logic               r_frame_sync;
  logic [c_ST_W-1:0]  r_state;
  logic [c_ST_W-1:0]  w_state_next;
  logic               w_drv_reset;
  logic               w_frame_edge;

  logic [c_RGB_W-1:0] r_back  [NUM_LEDS];
  logic [c_RGB_W-1:0] r_front [NUM_LEDS];

  logic [1:0]         w_gnt;
  logic [1:0]         w_ack;
  logic               w_wr_en;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [c_RGB_W-1:0] w_wr_data;
  logic [c_RGB_W-1:0] w_pix;

  logic [c_CH_W-1:0]  r_red;
  logic [c_CH_W-1:0]  r_green;
  logic [c_CH_W-1:0]  r_blue;

  // The first edge after reset release is treated as a frame start, so the
  // first frame gets its frame_sync pulse like every later one.
  assign w_frame_edge = !r_armed || (r_fc == c_FC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fc         <= '0;
      r_armed      <= 1'b0;
      r_frame_sync <= 1'b0;
    end else begin
      r_armed      <= 1'b1;
      r_frame_sync <= w_frame_edge;
      r_fc         <= w_frame_edge ? '0 : r_fc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_LATCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_LATCH: if (r_armed && (r_fc == c_FC_LATCH_END)) w_state_next = c_ST_RUN;
      c_ST_RUN:   if (r_fc == c_FC_LAST) w_state_next = c_ST_LATCH;
      default:    w_state_next = c_ST_LATCH;
    endcase
  end

  always_comb begin
    w_drv_reset = (r_state == c_ST_LATCH);
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (reset),
    .i_req ({b_req, a_req}),
    .o_gnt (w_gnt),
    .o_ack (w_ack)
  );

  assign w_wr_en   = |w_gnt;
  assign w_wr_addr = w_gnt[0] ? a_addr : b_addr;
  assign w_wr_data = w_gnt[0] ? a_rgb  : b_rgb;

  // Out-of-range addresses match no slot, so such writes are acked but dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_back[i]  <= '0;
        r_front[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_frame_edge) begin
          r_front[i] <= r_back[i];
        end
        if (w_wr_en && (w_wr_addr == ADDR_W'(i))) begin
          r_back[i] <= w_wr_data;
        end
      end
    end
  end

  always_comb begin
    w_pix = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (drv_address == ADDR_W'(i)) begin
        w_pix = r_front[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (drv_new_address) begin
      r_red   <= w_pix[2*c_CH_W +: c_CH_W] >> bright_shift;
      r_green <= w_pix[1*c_CH_W +: c_CH_W] >> bright_shift;
      r_blue  <= w_pix[0*c_CH_W +: c_CH_W] >> bright_shift;
    end
  end

  assign a_ack      = w_ack[0];
  assign b_ack      = w_ack[1];
  assign drv_red    = r_red;
  assign drv_green  = r_green;
  assign drv_blue   = r_blue;
  assign drv_reset  = w_drv_reset;
  assign frame_sync = r_frame_sync;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_frame_sched
// Description : Directed plus randomized bench for ws2812_frame_sched against
//               a cycle-indexed behavioural model of the frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_sched;

  localparam int NUM_LEDS = 8;
  localparam int ADDR_W   = 4;
  localparam int FC       = 100;
  localparam int RC       = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_req, b_req;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [23:0]       a_rgb, b_rgb;
  logic              a_ack, b_ack;
  logic [2:0]        bright_shift;
  logic [ADDR_W-1:0] drv_address;
  logic              drv_new_address;
  logic [7:0]        drv_red, drv_green, drv_blue;
  logic              drv_reset, frame_sync;

  always #5 clk = ~clk;

  ws2812_frame_sched #(
    .NUM_LEDS     (NUM_LEDS),
    .ADDR_W       (ADDR_W),
    .SYSTEM_CLOCK (1000),
    .FRAME_HZ     (10),
    .RESET_CYCLES (RC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .a_req           (a_req),
    .a_addr          (a_addr),
    .a_rgb           (a_rgb),
    .a_ack           (a_ack),
    .b_req           (b_req),
    .b_addr          (b_addr),
    .b_rgb           (b_rgb),
    .b_ack           (b_ack),
    .bright_shift    (bright_shift),
    .drv_address     (drv_address),
    .drv_new_address (drv_new_address),
    .drv_red         (drv_red),
    .drv_green       (drv_green),
    .drv_blue        (drv_blue),
    .drv_reset       (drv_reset),
    .frame_sync      (frame_sync)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          t;
  logic [23:0] m_back  [NUM_LEDS];
  logic [23:0] m_front [NUM_LEDS];
  logic        m_ack_a, m_ack_b, m_favor_b;
  logic [7:0]  m_r, m_g, m_b;
  bit          keep_req;
  logic [23:0] cur_a, cur_b, last_a, last_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LEDS; i++) begin
      m_back[i]  = '0;
      m_front[i] = '0;
    end
    m_ack_a = 0; m_ack_b = 0; m_favor_b = 0;
    m_r = 0; m_g = 0; m_b = 0;
    t = -1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a_ack"}, a_ack, 0);
    chk({tag, "_b_ack"}, b_ack, 0);
    chk({tag, "_pix"}, {drv_red, drv_green, drv_blue}, 0);
    chk({tag, "_drv_reset"}, drv_reset, 1);
    chk({tag, "_frame_sync"}, frame_sync, 0);
  endtask

  // Model one clock edge from the inputs now applied, then check all outputs.
  task automatic tick();
    logic [23:0] p;
    bit ea, eb, wa, wb;
    if (drv_new_address) begin
      p   = (drv_address < NUM_LEDS) ? m_front[drv_address[2:0]] : 24'h0;
      m_r = p[23:16] >> bright_shift;
      m_g = p[15:8]  >> bright_shift;
      m_b = p[7:0]   >> bright_shift;
    end
    ea = a_req && !m_ack_a;
    eb = b_req && !m_ack_b;
    wa = ea && (!eb || !m_favor_b);
    wb = eb && !wa;
    if (ea && eb) m_favor_b = wa;
    if ((t + 1) % FC == 0) begin
      for (int i = 0; i < NUM_LEDS; i++) m_front[i] = m_back[i];
    end
    if (wa && a_addr < NUM_LEDS) m_back[a_addr[2:0]] = a_rgb;
    if (wb && b_addr < NUM_LEDS) m_back[b_addr[2:0]] = b_rgb;
    m_ack_a = wa;
    m_ack_b = wb;
    @(posedge clk);
    #1;
    t++;
    chk($sformatf("a_ack@%0d", t), a_ack, m_ack_a);
    chk($sformatf("b_ack@%0d", t), b_ack, m_ack_b);
    chk($sformatf("frame_sync@%0d", t), frame_sync, (t % FC == 0));
    chk($sformatf("drv_reset@%0d", t), drv_reset, (t % FC < RC));
    chk($sformatf("pixel@%0d", t), {drv_red, drv_green, drv_blue}, {m_r, m_g, m_b});
    if (!keep_req) begin
      if (m_ack_a) a_req = 0;
      if (m_ack_b) b_req = 0;
    end
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  task automatic wr(input bit port_b, input logic [ADDR_W-1:0] addr, input logic [23:0] rgb);
    if (port_b) begin b_req = 1; b_addr = addr; b_rgb = rgb; end
    else        begin a_req = 1; a_addr = addr; a_rgb = rgb; end
    tick();
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] addr);
    drv_new_address = 1;
    drv_address     = addr;
    tick();
    drv_new_address = 0;
  endtask

  initial begin
    reset = 1; keep_req = 0;
    a_req = 0; a_addr = 0; a_rgb = 0;
    b_req = 0; b_addr = 0; b_rgb = 0;
    bright_shift = 0; drv_address = 0; drv_new_address = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    reset = 0;

    // Frame timing and the first write.
    tick();
    chk("frame_sync_c0", frame_sync, 1);
    run_to(9);
    chk("drv_reset_c9", drv_reset, 1);
    run_to(20);
    wr(0, 2, 24'h0600FF);
    chk("a_ack_c21", a_ack, 1);
    run_to(50);
    fetch(2);
    chk("fetch2_frame0", {drv_red, drv_green, drv_blue}, 24'h0);

    // Contested requests held high: grants must alternate A, B, A, B, ...
    run_to(60);
    a_addr = 3; b_addr = 4;
    a_rgb = 24'($urandom); b_rgb = 24'($urandom);
    a_req = 1; b_req = 1; keep_req = 1;
    for (int i = 0; i < 6; i++) begin
      cur_a = a_rgb; cur_b = b_rgb;
      tick();
      chk($sformatf("alt_grant%0d", i), {a_ack, b_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (m_ack_a) begin last_a = cur_a; a_rgb = 24'($urandom); end
      if (m_ack_b) begin last_b = cur_b; b_rgb = 24'($urandom); end
    end
    a_req = 0; b_req = 0; keep_req = 0;

    // Write landing on the frame-start edge misses this frame's copy.
    run_to(99);
    wr(0, 5, 24'h123456);
    chk("frame_sync_c100", frame_sync, 1);
    chk("drv_reset_c100", drv_reset, 1);
    run_to(105);
    fetch(2);
    chk("fetch2_frame1", {drv_red, drv_green, drv_blue}, 24'h0600FF);
    fetch(5);
    chk("fetch5_frame1", {drv_red, drv_green, drv_blue}, 24'h0);
    fetch(3);
    chk("alt_last_a", {drv_red, drv_green, drv_blue}, last_a);
    fetch(4);
    chk("alt_last_b", {drv_red, drv_green, drv_blue}, last_b);
    run_to(110);
    wr(1, 1, 24'h804010);
    chk("b_ack_c111", b_ack, 1);
    run_to(120);
    wr(0, 8, 24'hABCDEF);
    chk("a_ack_oor", a_ack, 1);

    run_to(200);
    chk("frame_sync_c200", frame_sync, 1);
    run_to(205);
    fetch(5);
    chk("fetch5_frame2", {drv_red, drv_green, drv_blue}, 24'h123456);
    bright_shift = 2;
    fetch(1);
    chk("bright2", {drv_red, drv_green, drv_blue}, 24'h201004);
    fetch(9);
    chk("fetch_oor", {drv_red, drv_green, drv_blue}, 24'h0);
    bright_shift = 7;
    fetch(1);
    chk("bright7", {drv_red, drv_green, drv_blue}, 24'h010000);
    bright_shift = 0;
    fetch(0);
    chk("oor_write_no_alias", {drv_red, drv_green, drv_blue}, 24'h0);

    // Asynchronous reset with a pending B request.
    run_to(250);
    b_req = 1; b_addr = 6; b_rgb = 24'h00AA55;
    reset = 1;
    #1;
    check_reset("midrst");
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_b_ack%0d", i), b_ack, 0);
    end
    reset = 0;
    tick();
    chk("b_ack_after_reset", b_ack, 1);
    run_to(5);
    fetch(6);
    chk("fetch6_same_frame", {drv_red, drv_green, drv_blue}, 24'h0);
    fetch(2);
    chk("fetch2_cleared", {drv_red, drv_green, drv_blue}, 24'h0);
    run_to(105);
    fetch(6);
    chk("fetch6_next_frame", {drv_red, drv_green, drv_blue}, 24'h00AA55);

    // Randomized traffic on both ports and the driver side.
    for (int c = 0; c < 700; c++) begin
      if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1; a_addr = 4'($urandom); a_rgb = 24'($urandom);
      end
      if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1; b_addr = 4'($urandom); b_rgb = 24'($urandom);
      end
      drv_new_address = ($urandom_range(0, 3) == 0);
      drv_address     = 4'($urandom_range(0, 9));
      bright_shift    = 3'($urandom);
      tick();
    end
    drv_new_address = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
